mem_log_trig: RTL and testbench

Multi-channel capture memory with decimation and trigger modes; next generation of the single-channel capture logger.
- Mode 0 (one-shot): fills the buffer once from run start.
- Mode 1 (circular): records continuously until a stop trigger, then a programmable number of post-trigger samples.
- Host reads back per channel. In mode 1 readback is oldest-sample-first.
- Sits between the DSP datapath taps and the register/host read interface.

---
 rtl/mem_log_trig.sv | 213 +++++++++++++++++++++
 tb/tb_mem_log_trig.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_log_trig.sv
// ---------------------------------------------------------------------------
// mem_log_trig
// Multi-channel capture memory sitting between the DSP datapath taps and the
// host read interface. All NCH channels are sampled together, optionally
// decimated, into a per-channel RAM of 2**RAM_ADDR_NBIT words.
//   Mode 0 (one-shot) : fills the buffer once from run start, then stops.
//   Mode 1 (circular) : records continuously until i_stop, then records
//                       a programmable number of post-trigger samples. Host
//                       readback is oldest-sample-first once wrapped.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   i_run        rising edge starts / restarts capture (any state)
//   i_stop       trigger level, mode 1 only
//   i_mode       0 one-shot, 1 circular/trigger (latched at start)
//   i_post_cnt   post-trigger sample count (latched at start)
//   i_decim      store one sample every i_decim+1 clocks (latched at start)
//   i_data       channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   i_read       read enable (ignored while busy)
//   i_ch         read channel select; out-of-range channels read as 0
//   i_address    logical read address
//   o_data       registered read data, 1-cycle latency, holds otherwise
//   o_mem_full   capture complete
//   o_busy       capturing (CAPTURE or POST)
//   o_trig_addr  physical address of the trigger sample
//   o_wrapped    circular buffer wrapped at least once
// ---------------------------------------------------------------------------
module mem_log_trig #(
    parameter int DATA_WIDTH    = 32,
    parameter int NCH           = 2,
    parameter int CH_NBIT       = 1,
    parameter int RAM_ADDR_NBIT = 10,
    parameter int DEC_NBIT      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_run,
    input  logic                      i_stop,
    input  logic                      i_mode,
    input  logic [RAM_ADDR_NBIT-1:0]  i_post_cnt,
    input  logic [DEC_NBIT-1:0]       i_decim,
    input  logic [NCH*DATA_WIDTH-1:0] i_data,
    input  logic                      i_read,
    input  logic [CH_NBIT-1:0]        i_ch,
    input  logic [RAM_ADDR_NBIT-1:0]  i_address,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_mem_full,
    output logic                      o_busy,
    output logic [RAM_ADDR_NBIT-1:0]  o_trig_addr,
    output logic                      o_wrapped
);

    localparam int DEPTH = 2 ** RAM_ADDR_NBIT;
    localparam logic [RAM_ADDR_NBIT-1:0] LAST_ADDR = {RAM_ADDR_NBIT{1'b1}};
    // NCH always fits in CH_NBIT+1 bits because 2**CH_NBIT >= NCH
    localparam logic [CH_NBIT:0] NCH_W = (CH_NBIT + 1)'(NCH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_FULL    = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_run_d;
    logic                       r_mode;
    logic [RAM_ADDR_NBIT-1:0]   r_post_cnt_l;
    logic [DEC_NBIT-1:0]        r_decim_l;
    logic [DEC_NBIT-1:0]        r_dec_cnt;
    logic [RAM_ADDR_NBIT-1:0]   r_wr_ptr;
    logic [RAM_ADDR_NBIT-1:0]   r_post_left;

    logic                       w_run_edge;
    logic                       w_active;
    logic                       w_tick;
    logic                       w_we;
    logic                       w_trig;
    logic [RAM_ADDR_NBIT-1:0]   w_phys;
    logic [DATA_WIDTH-1:0]      w_rd_ch [NCH];

    assign w_run_edge = i_run & ~r_run_d;
    assign w_active   = (r_state == ST_CAPTURE) || (r_state == ST_POST);
    assign w_tick     = w_active && (r_dec_cnt == r_decim_l);
    // A restart cycle belongs to the new capture, so the old capture's
    // tick in that cycle is dropped; reset also blocks writes.
    assign w_we       = w_tick & ~w_run_edge & rst;
    // Once a circular capture has wrapped, wr_ptr points at the oldest sample
    assign w_phys     = (r_mode && o_wrapped) ? (i_address + r_wr_ptr) : i_address;

    // Per-channel sample RAM; contents survive reset.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];

        // RAM write port: all channels stored at the same wr_ptr on a tick
        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[r_wr_ptr] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        assign w_rd_ch[k] = r_mem[w_phys];
    end

    // Next-state logic; a run edge beats a simultaneous stop
    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        if (w_run_edge) begin
            w_state_nxt = ST_CAPTURE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (!r_mode) begin
                        if (w_tick && (r_wr_ptr == LAST_ADDR)) begin
                            w_state_nxt = ST_FULL;
                        end else begin
                            w_state_nxt = ST_CAPTURE;
                        end
                    end else if (i_stop) begin
                        w_trig = 1'b1;
                        if (r_post_cnt_l == {RAM_ADDR_NBIT{1'b0}}) begin
                            w_state_nxt = ST_FULL;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end else begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_POST: begin
                    if (w_tick && (r_post_left == RAM_ADDR_NBIT'(1))) begin
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_state_nxt = ST_POST;
                    end
                end
                ST_FULL: begin
                    w_state_nxt = ST_FULL;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, capture control, status outputs and registered read port
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            // Tracks i_run through reset so a level held across reset
            // release is not mistaken for a new run edge.
            r_run_d      <= i_run;
            r_mode       <= 1'b0;
            r_post_cnt_l <= {RAM_ADDR_NBIT{1'b0}};
            r_decim_l    <= {DEC_NBIT{1'b0}};
            r_dec_cnt    <= {DEC_NBIT{1'b0}};
            r_wr_ptr     <= {RAM_ADDR_NBIT{1'b0}};
            r_post_left  <= {RAM_ADDR_NBIT{1'b0}};
            o_data       <= {DATA_WIDTH{1'b0}};
            o_mem_full   <= 1'b0;
            o_busy       <= 1'b0;
            o_trig_addr  <= {RAM_ADDR_NBIT{1'b0}};
            o_wrapped    <= 1'b0;
        end else begin
            r_run_d    <= i_run;
            r_state    <= w_state_nxt;
            o_busy     <= (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_POST);
            o_mem_full <= (w_state_nxt == ST_FULL);

            if (w_run_edge) begin
                r_mode       <= i_mode;
                r_post_cnt_l <= i_post_cnt;
                r_decim_l    <= i_decim;
                r_dec_cnt    <= {DEC_NBIT{1'b0}};
                r_wr_ptr     <= {RAM_ADDR_NBIT{1'b0}};
                o_wrapped    <= 1'b0;
                o_trig_addr  <= {RAM_ADDR_NBIT{1'b0}};
            end else begin
                if (w_active) begin
                    r_dec_cnt <= w_tick ? {DEC_NBIT{1'b0}} : (r_dec_cnt + DEC_NBIT'(1));
                end
                if (w_tick) begin
                    r_wr_ptr <= r_wr_ptr + RAM_ADDR_NBIT'(1);
                    if (r_mode && (r_wr_ptr == LAST_ADDR)) begin
                        o_wrapped <= 1'b1;
                    end
                end
                if (w_trig) begin
                    o_trig_addr <= r_wr_ptr;
                    r_post_left <= r_post_cnt_l;
                end else if ((r_state == ST_POST) && w_tick) begin
                    r_post_left <= r_post_left - RAM_ADDR_NBIT'(1);
                end
            end

            if (i_read && !o_busy) begin
                if ({1'b0, i_ch} < NCH_W) begin
                    o_data <= w_rd_ch[i_ch];
                end else begin
                    o_data <= {DATA_WIDTH{1'b0}};
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_log_trig.sv
module tb_mem_log_trig;

    localparam int DW  = 32;
    localparam int NC  = 2;
    localparam int CHN = 1;
    localparam int AW  = 3;
    localparam int DN  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_run, i_stop, i_mode, i_read;
    logic [AW-1:0]     i_post_cnt, i_address, o_trig_addr;
    logic [DN-1:0]     i_decim;
    logic [NC*DW-1:0]  i_data;
    logic [CHN-1:0]    i_ch;
    logic [DW-1:0]     o_data;
    logic              o_mem_full, o_busy, o_wrapped;

    int n;
    int n_run;
    int compared   = 0;
    int mismatched = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_v;
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    // ch0 = n, ch1 = n + 100; n advances once per clock
    assign i_data = {DW'(n + 100), DW'(n)};

    mem_log_trig #(
        .DATA_WIDTH(DW), .NCH(NC), .CH_NBIT(CHN), .RAM_ADDR_NBIT(AW), .DEC_NBIT(DN)
    ) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_stop(i_stop), .i_mode(i_mode),
        .i_post_cnt(i_post_cnt), .i_decim(i_decim), .i_data(i_data),
        .i_read(i_read), .i_ch(i_ch), .i_address(i_address),
        .o_data(o_data), .o_mem_full(o_mem_full), .o_busy(o_busy),
        .o_trig_addr(o_trig_addr), .o_wrapped(o_wrapped)
    );

    // one clock: outputs are sampled and inputs changed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_run = 1'b1;
        repeat (3) step();
        compared++; if (o_data !== 32'd0) begin mismatched++; $display("FAIL rst_data got %0d want 0", o_data); end
        compared++; if (o_mem_full !== 1'b0) begin mismatched++; $display("FAIL rst_full got %0b want 0", o_mem_full); end
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %0b want 0", o_busy); end
        compared++; if (o_trig_addr !== 3'd0) begin mismatched++; $display("FAIL rst_trig got %0d want 0", o_trig_addr); end
        compared++; if (o_wrapped !== 1'b0) begin mismatched++; $display("FAIL rst_wrapped got %0b want 0", o_wrapped); end
        rst = 1'b1;
        repeat (3) step();
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL rst_release_no_edge got busy=%0b want 0", o_busy); end
        i_run = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        i_mode = 1'b0; i_decim = 8'd0; i_post_cnt = 3'd0;
        i_run = 1'b1; n_run = n; step(); i_run = 1'b0;
        compared++; if (o_busy !== 1'b1) begin mismatched++; $display("FAIL os_busy got %0b want 1", o_busy); end
        repeat (7) step();
        compared++; if (o_mem_full !== 1'b0) begin mismatched++; $display("FAIL os_full_early got %0b want 0", o_mem_full); end
        step();
        compared++; if (o_mem_full !== 1'b1) begin mismatched++; $display("FAIL os_full got %0b want 1", o_mem_full); end
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL os_busy_end got %0b want 0", o_busy); end
        i_read = 1'b1; i_ch = 1'b1; i_address = 3'd3;
        exp_q.push_back(DW'(n_run + 4 + 100));
        step();
        exp_v = exp_q.pop_front();
        compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL os_ch1_a3 got %0d want %0d", o_data, exp_v); end
        for (int a = 0; a < 8; a++) begin
            i_ch = 1'b0; i_address = AW'(a);
            exp_q.push_back(DW'(n_run + 1 + a));
            step();
            exp_v = exp_q.pop_front();
            compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL os_ch0_a%0d got %0d want %0d", a, o_data, exp_v); end
            last_rd = exp_v;
        end
        i_read = 1'b0;
    endtask

    task automatic test_decim();
        i_mode = 1'b0; i_decim = 8'd2;
        i_run = 1'b1; n_run = n; step(); i_run = 1'b0;
        repeat (23) step();
        compared++; if (o_mem_full !== 1'b0) begin mismatched++; $display("FAIL dec_full_early got %0b want 0", o_mem_full); end
        step();
        compared++; if (o_mem_full !== 1'b1) begin mismatched++; $display("FAIL dec_full_24 got %0b want 1", o_mem_full); end
        i_read = 1'b1;
        for (int a = 0; a < 8; a++) begin
            i_ch = 1'b0; i_address = AW'(a);
            exp_q.push_back(DW'(n_run + 3 * (a + 1)));
            step();
            exp_v = exp_q.pop_front();
            compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL dec_ch0_a%0d got %0d want %0d", a, o_data, exp_v); end
        end
        i_ch = 1'b1; i_address = 3'd7;
        exp_q.push_back(DW'(n_run + 24 + 100));
        step();
        exp_v = exp_q.pop_front();
        compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL dec_ch1_a7 got %0d want %0d", o_data, exp_v); end
        last_rd = exp_v;
        i_read = 1'b0; i_decim = 8'd0;
    endtask

    task automatic test_trigger();
        i_mode = 1'b1; i_post_cnt = 3'd3;
        i_run = 1'b1; n_run = n; step(); i_run = 1'b0;
        repeat (13) step();
        compared++; if (o_wrapped !== 1'b1) begin mismatched++; $display("FAIL trg_wrapped got %0b want 1", o_wrapped); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        compared++; if (o_trig_addr !== 3'd5) begin mismatched++; $display("FAIL trg_addr got %0d want 5", o_trig_addr); end
        repeat (2) step();
        compared++; if (o_busy !== 1'b1) begin mismatched++; $display("FAIL trg_post_busy got %0b want 1", o_busy); end
        step();
        compared++; if (o_mem_full !== 1'b1) begin mismatched++; $display("FAIL trg_full got %0b want 1", o_mem_full); end
        i_read = 1'b1;
        for (int l = 0; l < 8; l++) begin
            i_ch = 1'b0; i_address = AW'(l);
            exp_q.push_back(DW'(n_run + 10 + l));
            step();
            exp_v = exp_q.pop_front();
            compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL trg_log%0d got %0d want %0d", l, o_data, exp_v); end
        end
        i_ch = 1'b1; i_address = 3'd7;
        exp_q.push_back(DW'(n_run + 17 + 100));
        step();
        exp_v = exp_q.pop_front();
        compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL trg_ch1_newest got %0d want %0d", o_data, exp_v); end
        last_rd = exp_v;
        i_read = 1'b0;
    endtask

    task automatic test_post_zero();
        i_mode = 1'b1; i_post_cnt = 3'd0;
        i_run = 1'b1; n_run = n; step(); i_run = 1'b0;
        repeat (3) step();
        i_stop = 1'b1; step(); i_stop = 1'b0;
        compared++; if (o_mem_full !== 1'b1) begin mismatched++; $display("FAIL pz_full got %0b want 1", o_mem_full); end
        compared++; if (o_wrapped !== 1'b0) begin mismatched++; $display("FAIL pz_wrapped got %0b want 0", o_wrapped); end
        compared++; if (o_trig_addr !== 3'd3) begin mismatched++; $display("FAIL pz_trig got %0d want 3", o_trig_addr); end
        i_read = 1'b1;
        for (int a = 0; a < 4; a++) begin
            i_ch = 1'b0; i_address = AW'(a);
            exp_q.push_back(DW'(n_run + 1 + a));
            step();
            exp_v = exp_q.pop_front();
            compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL pz_a%0d got %0d want %0d", a, o_data, exp_v); end
            last_rd = exp_v;
        end
        i_read = 1'b0;
    endtask

    task automatic test_restart_abort();
        i_mode = 1'b1; i_post_cnt = 3'd5;
        i_run = 1'b1; step(); i_run = 1'b0;
        // read while busy must leave o_data untouched
        i_read = 1'b1; i_ch = 1'b0; i_address = 3'd0;
        exp_q.push_back(last_rd);
        step();
        exp_v = exp_q.pop_front();
        compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL busy_read_hold got %0d want %0d", o_data, exp_v); end
        i_read = 1'b0;
        repeat (2) step();
        i_stop = 1'b1; step(); i_stop = 1'b0;
        compared++; if (o_busy !== 1'b1) begin mismatched++; $display("FAIL rs_post_busy got %0b want 1", o_busy); end
        step();
        i_mode = 1'b0; i_run = 1'b1; n_run = n; step(); i_run = 1'b0;
        compared++; if (o_mem_full !== 1'b0) begin mismatched++; $display("FAIL rs_full got %0b want 0", o_mem_full); end
        compared++; if (o_trig_addr !== 3'd0) begin mismatched++; $display("FAIL rs_trig got %0d want 0", o_trig_addr); end
        compared++; if (o_busy !== 1'b1) begin mismatched++; $display("FAIL rs_busy got %0b want 1", o_busy); end
        repeat (8) step();
        compared++; if (o_mem_full !== 1'b1) begin mismatched++; $display("FAIL rs_full_end got %0b want 1", o_mem_full); end
        i_read = 1'b1; i_ch = 1'b0; i_address = 3'd0;
        exp_q.push_back(DW'(n_run + 1));
        step();
        exp_v = exp_q.pop_front();
        compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL rs_a0 got %0d want %0d", o_data, exp_v); end
        i_address = 3'd7;
        exp_q.push_back(DW'(n_run + 8));
        step();
        exp_v = exp_q.pop_front();
        compared++; if (o_data !== exp_v) begin mismatched++; $display("FAIL rs_a7 got %0d want %0d", o_data, exp_v); end
        i_read = 1'b0;
        // abort a capture with reset
        i_run = 1'b1; step(); i_run = 1'b0;
        repeat (2) step();
        compared++; if (o_busy !== 1'b1) begin mismatched++; $display("FAIL ab_busy_pre got %0b want 1", o_busy); end
        rst = 1'b0; step(); rst = 1'b1;
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL ab_busy got %0b want 0", o_busy); end
        compared++; if (o_mem_full !== 1'b0) begin mismatched++; $display("FAIL ab_full got %0b want 0", o_mem_full); end
        compared++; if (o_data !== 32'd0) begin mismatched++; $display("FAIL ab_data got %0d want 0", o_data); end
        repeat (3) step();
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL ab_idle got %0b want 0", o_busy); end
    endtask

    initial begin
        n = 0; rst = 1'b0; i_run = 1'b0; i_stop = 1'b0; i_mode = 1'b0;
        i_post_cnt = 3'd0; i_decim = 8'd0; i_read = 1'b0; i_ch = 1'b0;
        i_address = 3'd0; last_rd = 32'd0;
        test_reset();
        test_oneshot();
        test_decim();
        test_trigger();
        test_post_zero();
        test_restart_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
